// File: rtl/itch_snapshot_ctrl.sv
// Snapshot controller between the ITCH parser and the AXI4-Lite read block:
// type-filters parsed messages, holds a coherent snapshot until software acks.
module itch_snapshot_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 in_valid,
  input  logic [3:0]           in_type,
  input  logic [63:0]          in_order_ref,
  input  logic                 in_side,
  input  logic [31:0]          in_shares,
  input  logic [31:0]          in_price,
  input  logic [63:0]          in_new_order_ref,
  input  logic [47:0]          in_timestamp,
  input  logic [63:0]          in_misc_data,
  input  logic                 cfg_enable,
  input  logic                 cfg_mode,
  input  logic [15:0]          cfg_type_mask,
  input  logic                 sw_ack,
  output logic                 latched_valid,
  output logic [3:0]           latched_type,
  output logic [63:0]          latched_order_ref,
  output logic                 latched_side,
  output logic [31:0]          latched_shares,
  output logic [31:0]          latched_price,
  output logic [63:0]          latched_new_order_ref,
  output logic [47:0]          latched_timestamp,
  output logic [63:0]          latched_misc_data,
  output logic                 pending_valid,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] msg_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [1:0]           dbg_state
);

  localparam int MW = 309;
  localparam logic [1:0] EMPTY     = 2'd0;
  localparam logic [1:0] HELD      = 2'd1;
  localparam logic [1:0] HELD_PEND = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [MW-1:0]        lat_q, lat_d;
  logic [MW-1:0]        pend_q, pend_d;
  logic [CNT_WIDTH-1:0] msg_q, msg_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 drop_inc;
  logic                 accept;
  logic [MW-1:0]        in_msg;

  // All fields travel as one packed word so a snapshot can never mix messages.
  assign in_msg = {in_type, in_order_ref, in_side, in_shares, in_price,
                   in_new_order_ref, in_timestamp, in_misc_data};
  assign accept = in_valid & cfg_enable & cfg_type_mask[in_type];

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    pend_d   = pend_q;
    drop_inc = 1'b0;
    if (cfg_mode) begin
      // A pending message left over from hold-first mode is discarded here.
      if (state_q == HELD_PEND) begin
        drop_inc = 1'b1;
        state_d  = HELD;
        if (accept) lat_d = in_msg;
      end else if (accept) begin
        lat_d   = in_msg;
        state_d = HELD;
      end else if (state_q == HELD && sw_ack) begin
        state_d = EMPTY;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            lat_d   = in_msg;
            state_d = HELD;
          end
        end
        HELD: begin
          if (accept && !sw_ack) begin
            pend_d  = in_msg;
            state_d = HELD_PEND;
          end else if (sw_ack && !accept) begin
            state_d = EMPTY;
          end else if (sw_ack && accept) begin
            lat_d = in_msg;
          end
        end
        HELD_PEND: begin
          if (accept && !sw_ack) begin
            drop_inc = 1'b1;
          end else if (sw_ack) begin
            lat_d   = pend_q;
            state_d = HELD;
            if (accept) begin
              pend_d  = in_msg;
              state_d = HELD_PEND;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign msg_d  = msg_q + {{(CNT_WIDTH-1){1'b0}}, accept};
  assign drop_d = (drop_inc && (drop_q != {CNT_WIDTH{1'b1}})) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= EMPTY;
      lat_q   <= '0;
      pend_q  <= '0;
      msg_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
      msg_q   <= msg_d;
      drop_q  <= drop_d;
    end
  end

  assign {latched_type, latched_order_ref, latched_side, latched_shares, latched_price,
          latched_new_order_ref, latched_timestamp, latched_misc_data} = lat_q;
  assign latched_valid = (state_q != EMPTY);
  assign pending_valid = (state_q == HELD_PEND);
  assign irq           = latched_valid;
  assign msg_count     = msg_q;
  assign drop_count    = drop_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_itch_snapshot_ctrl.sv
// Bench for itch_snapshot_ctrl (CNT_WIDTH=4 so counter wrap and saturation are reachable).
module tb_itch_snapshot_ctrl;

  localparam int CW = 4;
  localparam int MW = 309;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_side, cfg_enable, cfg_mode, sw_ack;
  logic [3:0]    in_type;
  logic [63:0]   in_order_ref, in_new_order_ref, in_misc_data;
  logic [31:0]   in_shares, in_price;
  logic [47:0]   in_timestamp;
  logic [15:0]   cfg_type_mask;
  logic          latched_valid, latched_side, pending_valid, irq;
  logic [3:0]    latched_type;
  logic [63:0]   latched_order_ref, latched_new_order_ref, latched_misc_data;
  logic [31:0]   latched_shares, latched_price;
  logic [47:0]   latched_timestamp;
  logic [CW-1:0] msg_count, drop_count;
  logic [1:0]    dbg_state;

  itch_snapshot_ctrl #(.CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .in_valid(in_valid), .in_type(in_type), .in_order_ref(in_order_ref),
    .in_side(in_side), .in_shares(in_shares), .in_price(in_price),
    .in_new_order_ref(in_new_order_ref), .in_timestamp(in_timestamp),
    .in_misc_data(in_misc_data), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_type_mask(cfg_type_mask), .sw_ack(sw_ack),
    .latched_valid(latched_valid), .latched_type(latched_type),
    .latched_order_ref(latched_order_ref), .latched_side(latched_side),
    .latched_shares(latched_shares), .latched_price(latched_price),
    .latched_new_order_ref(latched_new_order_ref), .latched_timestamp(latched_timestamp),
    .latched_misc_data(latched_misc_data), .pending_valid(pending_valid), .irq(irq),
    .msg_count(msg_count), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int errors  = 0;
  logic [MW-1:0] exp_q[$];
  logic [CW-1:0] exp_mc = '0;
  logic [CW-1:0] exp_dc = '0;

  wire [MW-1:0] snap = {latched_type, latched_order_ref, latched_side, latched_shares,
                        latched_price, latched_new_order_ref, latched_timestamp,
                        latched_misc_data};

  // scoreboard: every change of the snapshot word consumes one expected entry
  logic [MW-1:0] prev_snap = '0;
  logic [MW-1:0] exp_snap;
  always @(negedge clk) begin
    if (snap !== prev_snap) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL snapshot_unexpected: got %h, expected no change", snap);
      end else begin
        exp_snap = exp_q.pop_front();
        if (snap !== exp_snap) begin
          errors++;
          $display("FAIL snapshot: got %h, expected %h", snap, exp_snap);
        end
      end
      prev_snap = snap;
    end
  end

  function automatic logic [MW-1:0] gen_msg(input logic [3:0] t, input logic [31:0] price);
    logic [63:0] oref, nref, misc;
    logic [47:0] ts;
    logic [31:0] shares;
    oref   = {$urandom, $urandom};
    nref   = {$urandom, $urandom};
    misc   = {$urandom, $urandom};
    ts     = {16'($urandom), $urandom};
    shares = $urandom;
    return {t, oref, 1'($urandom_range(0, 1)), shares, price, nref, ts, misc};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // driver: present inputs for exactly one rising edge; returns at the next negedge
  task automatic drive(input logic v, input logic [MW-1:0] m, input logic ack);
    in_valid = v;
    {in_type, in_order_ref, in_side, in_shares, in_price,
     in_new_order_ref, in_timestamp, in_misc_data} = m;
    sw_ack = ack;
    @(negedge clk);
    in_valid = 1'b0;
    sw_ack   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 0; sw_ack = 0; cfg_enable = 1; cfg_mode = 0; cfg_type_mask = 16'hFFFF;
    {in_type, in_order_ref, in_side, in_shares, in_price,
     in_new_order_ref, in_timestamp, in_misc_data} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({latched_valid, pending_valid, irq, msg_count, drop_count, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_status: got %b, expected all zero",
               {latched_valid, pending_valid, irq, msg_count, drop_count, dbg_state});
    end
    vectors++;
    if (snap !== '0) begin
      errors++;
      $display("FAIL reset_snapshot: got %h, expected 0", snap);
    end
  endtask

  task automatic test_single;
    logic [MW-1:0] a;
    a = gen_msg(4'h3, 32'd10050);
    exp_q.push_back(a); exp_mc++;
    drive(1, a, 0);
    vectors++;
    if ({latched_valid, irq, latched_price, msg_count} !== {1'b1, 1'b1, 32'd10050, exp_mc}) begin
      errors++;
      $display("FAIL single_latch: got v=%b irq=%b price=%0d mc=%0d, expected 1 1 10050 %0d",
               latched_valid, irq, latched_price, msg_count, exp_mc);
    end
    drive(0, '0, 1);
    vectors++;
    if ({latched_valid, irq, latched_price} !== {1'b0, 1'b0, 32'd10050}) begin
      errors++;
      $display("FAIL single_ack: got v=%b irq=%b price=%0d, expected 0 0 10050",
               latched_valid, irq, latched_price);
    end
  endtask

  task automatic test_hold_pend;
    logic [MW-1:0] a, b, c;
    a = gen_msg(4'h1, 32'd111); b = gen_msg(4'h2, 32'd222); c = gen_msg(4'h4, 32'd333);
    exp_q.push_back(a);
    drive(1, a, 0); drive(1, b, 0); drive(1, c, 0);
    exp_mc += 3; exp_dc = sat_inc(exp_dc);
    vectors++;
    if ({latched_valid, pending_valid, msg_count, drop_count, latched_price} !==
        {1'b1, 1'b1, exp_mc, exp_dc, 32'd111}) begin
      errors++;
      $display("FAIL hold_pend_status: got lv=%b pv=%b mc=%0d dc=%0d price=%0d, expected 1 1 %0d %0d 111",
               latched_valid, pending_valid, msg_count, drop_count, latched_price, exp_mc, exp_dc);
    end
    exp_q.push_back(b);
    drive(0, '0, 1);
    vectors++;
    if ({latched_valid, pending_valid, latched_price} !== {1'b1, 1'b0, 32'd222}) begin
      errors++;
      $display("FAIL hold_pend_promote: got lv=%b pv=%b price=%0d, expected 1 0 222",
               latched_valid, pending_valid, latched_price);
    end
    drive(0, '0, 1);
    vectors++;
    if ({latched_valid, pending_valid, dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL hold_pend_empty: got lv=%b pv=%b st=%0d, expected 0 0 0",
               latched_valid, pending_valid, dbg_state);
    end
  endtask

  task automatic test_ack_with_msg;
    logic [MW-1:0] a, b, d;
    a = gen_msg(4'h6, 32'd10); b = gen_msg(4'h7, 32'd20); d = gen_msg(4'h8, 32'd30);
    exp_q.push_back(a);
    drive(1, a, 0); drive(1, b, 0);
    exp_q.push_back(b);
    drive(1, d, 1);
    exp_mc += 3;
    vectors++;
    if ({latched_valid, pending_valid, latched_price, msg_count, drop_count} !==
        {1'b1, 1'b1, 32'd20, exp_mc, exp_dc}) begin
      errors++;
      $display("FAIL ack_msg_status: got lv=%b pv=%b price=%0d mc=%0d dc=%0d, expected 1 1 20 %0d %0d",
               latched_valid, pending_valid, latched_price, msg_count, drop_count, exp_mc, exp_dc);
    end
    exp_q.push_back(d);
    drive(0, '0, 1);
    vectors++;
    if ({latched_valid, pending_valid, latched_price} !== {1'b1, 1'b0, 32'd30}) begin
      errors++;
      $display("FAIL ack_msg_promote: got lv=%b pv=%b price=%0d, expected 1 0 30",
               latched_valid, pending_valid, latched_price);
    end
    drive(0, '0, 1);
  endtask

  task automatic test_mask_enable;
    logic [MW-1:0] a, b, c;
    cfg_type_mask = 16'h0002;
    a = gen_msg(4'h1, 32'd41); b = gen_msg(4'h5, 32'd42); c = gen_msg(4'h1, 32'd43);
    exp_q.push_back(a); exp_mc++;
    drive(1, a, 0); drive(1, b, 0);
    cfg_enable = 1'b0;
    drive(1, c, 0);
    vectors++;
    if ({latched_valid, pending_valid, latched_type, latched_price, msg_count, drop_count} !==
        {1'b1, 1'b0, 4'h1, 32'd41, exp_mc, exp_dc}) begin
      errors++;
      $display("FAIL mask_enable: got lv=%b pv=%b t=%0d price=%0d mc=%0d dc=%0d, expected 1 0 1 41 %0d %0d",
               latched_valid, pending_valid, latched_type, latched_price, msg_count, drop_count,
               exp_mc, exp_dc);
    end
    drive(0, '0, 1);
    vectors++;
    if (latched_valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_ack: got lv=%b, expected 0", latched_valid);
    end
    cfg_enable = 1'b1; cfg_type_mask = 16'hFFFF;
  endtask

  task automatic test_overwrite;
    logic [MW-1:0] a, b;
    cfg_mode = 1'b1;
    a = gen_msg(4'h9, 32'd501); b = gen_msg(4'hA, 32'd502);
    exp_q.push_back(a); exp_q.push_back(b); exp_mc += 2;
    drive(1, a, 0); drive(1, b, 0);
    vectors++;
    if ({latched_valid, pending_valid, latched_price, msg_count, drop_count} !==
        {1'b1, 1'b0, 32'd502, exp_mc, exp_dc}) begin
      errors++;
      $display("FAIL overwrite: got lv=%b pv=%b price=%0d mc=%0d dc=%0d, expected 1 0 502 %0d %0d",
               latched_valid, pending_valid, latched_price, msg_count, drop_count, exp_mc, exp_dc);
    end
    drive(0, '0, 1);
    cfg_mode = 1'b0;
    a = gen_msg(4'hB, 32'd601); b = gen_msg(4'hC, 32'd602);
    exp_q.push_back(a); exp_mc += 2;
    drive(1, a, 0); drive(1, b, 0);
    cfg_mode = 1'b1;
    drive(0, '0, 0);
    exp_dc = sat_inc(exp_dc);
    vectors++;
    if ({latched_valid, pending_valid, latched_price, drop_count} !==
        {1'b1, 1'b0, 32'd601, exp_dc}) begin
      errors++;
      $display("FAIL mode_switch: got lv=%b pv=%b price=%0d dc=%0d, expected 1 0 601 %0d",
               latched_valid, pending_valid, latched_price, drop_count, exp_dc);
    end
    drive(0, '0, 1);
    cfg_mode = 1'b0;
  endtask

  task automatic test_drop_sat_and_reset;
    logic [MW-1:0] a;
    a = gen_msg(4'hD, 32'd701);
    exp_q.push_back(a);
    drive(1, a, 0);
    for (int i = 0; i < (1 << CW) + 3; i++) drive(1, gen_msg(4'($urandom_range(0, 15)), $urandom), 0);
    exp_mc += CW'((1 << CW) + 4);
    for (int i = 0; i < (1 << CW) + 2; i++) exp_dc = sat_inc(exp_dc);
    vectors++;
    if ({pending_valid, drop_count, msg_count} !== {1'b1, 4'hF, exp_mc}) begin
      errors++;
      $display("FAIL drop_sat: got pv=%b dc=%h mc=%h, expected 1 f %h",
               pending_valid, drop_count, msg_count, exp_mc);
    end
    exp_q.push_back('0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({latched_valid, pending_valid, irq, msg_count, drop_count, dbg_state, latched_price} !== '0) begin
      errors++;
      $display("FAIL async_reset: got lv=%b pv=%b irq=%b mc=%h dc=%h st=%0d price=%0d, expected all 0",
               latched_valid, pending_valid, irq, msg_count, drop_count, dbg_state, latched_price);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_mc = '0; exp_dc = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [MW-1:0] m;
    logic [3:0]    t;
    logic          any_acc;
    cfg_mode = 1'b1;
    cfg_type_mask = 16'($urandom_range(1, 16'hFFFF));
    any_acc = 1'b0;
    for (int i = 0; i < 24; i++) begin
      t = 4'($urandom_range(0, 15));
      m = gen_msg(t, $urandom);
      if (cfg_type_mask[t]) begin
        exp_q.push_back(m); exp_mc++; any_acc = 1'b1;
      end
      drive(1, m, 0);
    end
    vectors++;
    if ({latched_valid, pending_valid, msg_count, drop_count} !== {any_acc, 1'b0, exp_mc, exp_dc}) begin
      errors++;
      $display("FAIL back_to_back: got lv=%b pv=%b mc=%h dc=%h, expected %b 0 %h %h",
               latched_valid, pending_valid, msg_count, drop_count, any_acc, exp_mc, exp_dc);
    end
    drive(0, '0, 1);
    vectors++;
    if (latched_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_ack: got lv=%b, expected 0", latched_valid);
    end
    cfg_mode = 1'b0; cfg_type_mask = 16'hFFFF;
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_pend();
    test_ack_with_msg();
    test_mask_enable();
    test_overwrite();
    test_drop_sat_and_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/itch_snapshot_ctrl.md
# itch_snapshot_ctrl

Snapshot controller between the ITCH parser message outputs and the AXI4-Lite register read block. Filters parsed messages by type, captures them into a coherent latched snapshot that software reads field-by-field, and holds that snapshot stable until software acknowledges it. A one-deep pending buffer absorbs one extra message while the snapshot is held. Message and drop counters are exported for status registers.

## Interface
Parameters:
- CNT_WIDTH, 32, width of msg_count and drop_count

Ports:
- S_AXI_ACLK  in  1  single clock for all logic
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- in_valid  in  1  one-cycle pulse: parser message fields valid this cycle
- in_type  in  4  message type code
- in_order_ref  in  64  order reference
- in_side  in  1  buy/sell
- in_shares  in  32  shares
- in_price  in  32  price
- in_new_order_ref  in  64  replacement order reference
- in_timestamp  in  48  timestamp
- in_misc_data  in  64  type-specific data
- cfg_enable  in  1  1 = accept messages
- cfg_mode  in  1  0 = hold-first, 1 = overwrite-latest
- cfg_type_mask  in  16  bit n set = accept in_type == n
- sw_ack  in  1  one-cycle pulse: software finished reading snapshot
- latched_valid  out  1  snapshot held
- latched_type, latched_order_ref, latched_side, latched_shares, latched_price, latched_new_order_ref, latched_timestamp, latched_misc_data  out  same widths as in_*  snapshot fields
- pending_valid  out  1  pending buffer occupied
- irq  out  1  level, equals latched_valid
- msg_count  out  CNT_WIDTH  accepted messages, wraps
- drop_count  out  CNT_WIDTH  accepted-but-discarded messages, saturates at all-ones

## Operation
- accept = in_valid & cfg_enable & cfg_type_mask[in_type]. Non-accepted messages affect nothing.
- State machine: EMPTY, HELD, HELD_PEND. latched_valid = (state != EMPTY); pending_valid = (state == HELD_PEND).
- Hold-first mode (cfg_mode=0):
  - EMPTY: accept -> latched <= in, go HELD. sw_ack ignored.
  - HELD: accept & !sw_ack -> pending <= in, go HELD_PEND. sw_ack & !accept -> go EMPTY. sw_ack & accept -> latched <= in, stay HELD.
  - HELD_PEND: accept & !sw_ack -> message dropped, drop_count+1. sw_ack & !accept -> latched <= pending, go HELD. sw_ack & accept -> latched <= pending, pending <= in, stay HELD_PEND.
- Overwrite mode (cfg_mode=1): pending buffer unused.
  - Any state, accept -> latched <= in, go HELD (previous snapshot overwritten, not counted as drop).
  - HELD, sw_ack & !accept -> EMPTY.
  - HELD_PEND entered with cfg_mode=1 (mode switched while pending): pending discarded, drop_count+1, go HELD (or load in if accept that cycle). Transition takes one cycle.
- msg_count increments by 1 on every accept, wraps modulo 2^CNT_WIDTH. drop_count increments on each discard, holds at all-ones.
- On EMPTY transition, latched data fields retain last values; only latched_valid drops.
- cfg_enable=0: no accepts; held/pending contents and sw_ack handling unchanged.
- cfg_* are static-sampled each cycle; no synchronisation.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): state EMPTY; all latched_* fields, pending buffer, counters = 0; latched_valid, pending_valid, irq = 0.
- Latency: accepted message visible on latched_* and latched_valid on the cycle after in_valid (registered outputs, 1 cycle).
- sw_ack effect visible next cycle; promotion of pending to latched takes exactly 1 cycle after sw_ack.
- All latched_* fields update in the same cycle — never a mix of two messages.
- Counters update in the same cycle as the corresponding state change.
- Back-to-back in_valid every cycle fully supported; no backpressure to parser.
- Reset mid-operation discards snapshot and pending immediately.

## Test plan
- Reset, mask=16'hFFFF, mode=0: single message type 4'h3, price 32'd10050 -> next cycle latched_valid=1, latched_price=10050, msg_count=1; sw_ack -> latched_valid=0, latched_price still 10050.
- Mode 0, three messages A,B,C with no ack -> latched=A, pending=B, drop_count=1, msg_count=3; sw_ack -> latched=B, pending_valid=0; sw_ack -> EMPTY.
- Mode 0, HELD_PEND, sw_ack and message D same cycle -> latched=pending, pending=D, drop_count unchanged.
- Mask=16'h0002: messages type 1 and type 5 -> only type 1 latched, msg_count=1, drop_count=0; cfg_enable=0 message type 1 -> no change.
- Mode 1: messages A then B -> latched=B, drop_count=0; switch mode 0->1 while HELD_PEND -> pending cleared, drop_count+1.
- drop_count preset near max by forcing 2^CNT_WIDTH+2 drops (CNT_WIDTH=4 build) -> holds at 4'hF; async reset asserted mid-HELD_PEND -> all outputs 0 immediately.
